// File: rtl/mmio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mmio_pkg : register offsets, FSM encoding, default window base     |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package mmio_pkg;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

   localparam logic [4:0] OFF_PORTOUT = 5'h00;
   localparam logic [4:0] OFF_PORTIN  = 5'h04;
   localparam logic [4:0] OFF_EDGE    = 5'h08;
   localparam logic [4:0] OFF_IRQEN   = 5'h0C;
   localparam logic [4:0] OFF_TIMER   = 5'h10;
   localparam logic [4:0] OFF_TIMCMP  = 5'h14;
   localparam logic [4:0] OFF_STATUS  = 5'h18;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_edge_detect : 2-flop synchronizer with rising-edge pulse      |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module sync_edge_detect #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] sync_out,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] meta;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta   <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta   <= din;
         sync_q <= meta;
         prev_q <= sync_q;
      end
   end

   assign sync_out = sync_q;
   assign rise     = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/mmio_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mmio_responder : single-cycle MMIO slave with port, timer and IRQ  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module mmio_responder
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int          PORT_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [31:0]       Address,
   input  logic [31:0]       WriteData,
   output logic [31:0]       ReadData,
   output logic              Ready,
   input  logic [PORT_W-1:0] PortIn,
   output logic [31:0]       PortOut,
   output logic              IRQ
);

   state_t state;
   state_t next_state;
   logic   accept;
   logic   do_wr;
   logic   do_rd;

   logic [29:0] word_idx;
   logic        mapped;
   logic [4:0]  offset;
   logic        unused_addr_lsb;

   logic [PORT_W-1:0] sync_in;
   logic [PORT_W-1:0] rise;
   logic [PORT_W-1:0] edge_q;
   logic [PORT_W-1:0] edge_clr;
   logic [31:0]       edge_ext;
   logic [8:0]        irqen;
   logic [31:0]       timer;
   logic [31:0]       timcmp;
   logic [31:0]       timer_nxt;
   logic [31:0]       timcmp_nxt;
   logic              status;
   logic              status_set;
   logic [31:0]       rd_mux;

   logic sel_portout, sel_edge, sel_irqen, sel_timer, sel_timcmp, sel_status;

   sync_edge_detect #(
      .WIDTH (PORT_W)
   ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .din      (PortIn),
      .sync_out (sync_in),
      .rise     (rise)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (MemRead || MemWrite) begin
               next_state = RESP;
               accept     = 1'b1;
            end
         end
         RESP: next_state = IDLE;
      endcase
      do_wr = accept && MemWrite;
      do_rd = accept && MemRead && !MemWrite;
   end

   assign Ready = (state == RESP);

   // Word-granular decode so the low address bits never participate.
   assign word_idx        = Address[31:2] - BASE_ADDR[31:2];
   assign mapped          = (word_idx[29:3] == '0);
   assign offset          = {word_idx[2:0], 2'b00};
   assign unused_addr_lsb = ^Address[1:0];

   assign sel_portout = do_wr && mapped && (offset == OFF_PORTOUT);
   assign sel_edge    = do_wr && mapped && (offset == OFF_EDGE);
   assign sel_irqen   = do_wr && mapped && (offset == OFF_IRQEN);
   assign sel_timer   = do_wr && mapped && (offset == OFF_TIMER);
   assign sel_timcmp  = do_wr && mapped && (offset == OFF_TIMCMP);
   assign sel_status  = do_wr && mapped && (offset == OFF_STATUS);

   assign timer_nxt  = sel_timer  ? WriteData : timer + 32'd1;
   assign timcmp_nxt = sel_timcmp ? WriteData : timcmp;
   // Match on the post-edge values so STATUS rises together with the match.
   assign status_set = (timer_nxt == timcmp_nxt);
   assign edge_clr   = sel_edge ? WriteData[PORT_W-1:0] : '0;
   assign edge_ext   = 32'(edge_q);

   always_comb begin
      rd_mux = '0;
      if (mapped) begin
         case (offset)
            OFF_PORTOUT: rd_mux = PortOut;
            OFF_PORTIN:  rd_mux = 32'(sync_in);
            OFF_EDGE:    rd_mux = edge_ext;
            OFF_IRQEN:   rd_mux = {23'd0, irqen};
            OFF_TIMER:   rd_mux = timer;
            OFF_TIMCMP:  rd_mux = timcmp;
            OFF_STATUS:  rd_mux = {31'd0, status};
            default:     rd_mux = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         PortOut  <= '0;
         ReadData <= '0;
         IRQ      <= 1'b0;
         edge_q   <= '0;
         irqen    <= '0;
         timer    <= '0;
         timcmp   <= '0;
         status   <= 1'b0;
      end else begin
         if (sel_portout) PortOut <= WriteData;
         if (sel_irqen)   irqen   <= WriteData[8:0];
         timer    <= timer_nxt;
         timcmp   <= timcmp_nxt;
         status   <= status_set | (status & ~(sel_status & WriteData[0]));
         edge_q   <= (edge_q & ~edge_clr) | rise;
         IRQ      <= (|(edge_ext[7:0] & irqen[7:0])) | (status & irqen[8]);
         ReadData <= do_rd ? rd_mux : '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mmio_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mmio_responder : randomized bench with behavioural reference    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_mmio_responder;

   localparam logic [31:0] BASE = 32'hFFFF_0000;
   localparam int          PW   = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          MemRead = 1'b0;
   logic          MemWrite = 1'b0;
   logic [31:0]   Address = '0;
   logic [31:0]   WriteData = '0;
   logic [31:0]   ReadData;
   logic          Ready;
   logic [PW-1:0] PortIn = '0;
   logic [31:0]   PortOut;
   logic          IRQ;

   always #5 clk = ~clk;

   mmio_responder #(
      .BASE_ADDR (BASE),
      .PORT_W    (PW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .Address   (Address),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .Ready     (Ready),
      .PortIn    (PortIn),
      .PortOut   (PortOut),
      .IRQ       (IRQ)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: register file as the programmer sees it, one step per clock.
   logic          m_resp;
   logic [31:0]   m_rdata, m_portout, m_timer, m_timcmp;
   logic [8:0]    m_irqen;
   logic [PW-1:0] m_edge;
   logic          m_status, m_irq;
   logic [PW-1:0] m_hist [0:2];   // PortIn samples from the last three edges, newest first

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      logic [31:0] off;
      off = {addr[31:2], 2'b00} - BASE;
      case (off)
         32'h00:  return m_portout;
         32'h04:  return 32'(m_hist[1]);
         32'h08:  return 32'(m_edge);
         32'h0C:  return {23'd0, m_irqen};
         32'h10:  return m_timer;
         32'h14:  return m_timcmp;
         32'h18:  return {31'd0, m_status};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_resp = 0; m_rdata = 0; m_portout = 0; m_timer = 0; m_timcmp = 0;
      m_irqen = 0; m_edge = 0; m_status = 0; m_irq = 0;
      for (int i = 0; i < 3; i++) m_hist[i] = '0;
   endtask

   task automatic model_step();
      logic          acc, wr, rd, sclr;
      logic [31:0]   off, nt, ntc;
      logic [PW-1:0] clr, rise;
      acc  = !m_resp && (MemRead || MemWrite);
      wr   = acc && MemWrite;
      rd   = acc && MemRead && !MemWrite;
      off  = {Address[31:2], 2'b00} - BASE;
      rise = m_hist[1] & ~m_hist[2];
      m_irq   = (|(m_edge & PW'(m_irqen[7:0]))) || (m_status && m_irqen[8]);
      m_rdata = rd ? model_read(Address) : 32'd0;
      nt = m_timer + 32'd1;
      ntc = m_timcmp;
      clr = '0;
      sclr = 1'b0;
      if (wr) begin
         case (off)
            32'h00: m_portout = WriteData;
            32'h08: clr = WriteData[PW-1:0];
            32'h0C: m_irqen = WriteData[8:0];
            32'h10: nt = WriteData;
            32'h14: ntc = WriteData;
            32'h18: sclr = WriteData[0];
            default: ;
         endcase
      end
      m_status = (nt == ntc) || (m_status && !sclr);
      m_timer  = nt;
      m_timcmp = ntc;
      m_edge   = (m_edge & ~clr) | rise;
      m_resp   = acc;
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = PortIn;
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) model_reset();
      else        model_step();
   end

   always @(negedge clk) begin
      if (!reset) begin
         check("rst_ready", 32'(Ready), 32'd0);
         check("rst_irq", 32'(IRQ), 32'd0);
         check("rst_portout", PortOut, 32'd0);
         check("rst_readdata", ReadData, 32'd0);
      end else begin
         check("ready", 32'(Ready), 32'(m_resp));
         check("irq", 32'(IRQ), 32'(m_irq));
         check("portout", PortOut, m_portout);
         if (m_resp) check("readdata", ReadData, m_rdata);
      end
   end

   // Requester: holds the request through the RESP edge, drops it just after.
   task automatic bus(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata);
      int n;
      @(negedge clk);
      MemRead = rd; MemWrite = wr; Address = addr; WriteData = wdata;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!Ready && n < 8);
      check("latency", 32'(n), 32'd1);
      rdata = ReadData;
      @(posedge clk);
      #1;
      MemRead = 0; MemWrite = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, addr, wd;
      logic        irq3, irq4;
      int          n, op;

      repeat (3) @(negedge clk);
      reset = 1'b1;

      bus(0, 1, BASE, 32'h0000_00A5, rd);
      check("portout_a5", PortOut, 32'h0000_00A5);
      bus(1, 0, BASE, 32'd0, rd);
      check("read_portout", rd, 32'h0000_00A5);

      bus(0, 1, BASE + 32'h0C, 32'h003, rd);
      @(negedge clk);
      PortIn = 8'h03;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!IRQ && n < 10);
      check("edge_irq_latency", 32'(n), 32'd4);
      bus(1, 0, BASE + 32'h08, 32'd0, rd);
      check("edge_03", rd, 32'h03);
      bus(0, 1, BASE + 32'h08, 32'h01, rd);
      bus(1, 0, BASE + 32'h08, 32'd0, rd);
      check("edge_after_w1c", rd, 32'h02);
      check("irq_held", 32'(IRQ), 32'd1);

      bus(0, 1, BASE + 32'h14, 32'h1, rd);
      bus(0, 1, BASE + 32'h18, 32'h1, rd);
      bus(0, 1, BASE + 32'h0C, 32'h100, rd);
      bus(0, 1, BASE + 32'h10, 32'hFFFF_FFFE, rd);
      repeat (2) @(negedge clk);
      @(negedge clk); irq3 = IRQ;
      @(negedge clk); irq4 = IRQ;
      check("timer_irq_before", 32'(irq3), 32'd0);
      check("timer_irq_after", 32'(irq4), 32'd1);
      bus(1, 0, BASE + 32'h18, 32'd0, rd);
      check("status_set", rd, 32'd1);
      bus(0, 1, BASE + 32'h18, 32'h1, rd);
      bus(1, 0, BASE + 32'h18, 32'd0, rd);
      check("status_cleared", rd, 32'd0);

      bus(1, 1, BASE + 32'h14, 32'h55, rd);
      check("rw_readdata", rd, 32'd0);
      @(negedge clk);
      check("single_ready", 32'(Ready), 32'd0);
      bus(1, 0, BASE + 32'h14, 32'd0, rd);
      check("timcmp_55", rd, 32'h55);

      bus(1, 0, BASE + 32'h40, 32'd0, rd);
      check("unmapped_read", rd, 32'd0);
      bus(0, 1, BASE + 32'h20, 32'h1234, rd);
      check("unmapped_write", PortOut, 32'h0000_00A5);

      @(negedge clk);
      MemRead = 1; Address = BASE;
      @(posedge clk);
      #1;
      check("resp_before_abort", 32'(Ready), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check("abort_ready", 32'(Ready), 32'd0);
      check("abort_portout", PortOut, 32'd0);
      MemRead = 0;
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) PortIn = PW'($urandom);
         if ($urandom_range(0, 9) == 0)
            addr = BASE - 32'd4;
         else
            addr = BASE + 32'($urandom_range(0, 8) << 2) + 32'($urandom_range(0, 3));
         wd = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 511)) : $urandom;
         op = $urandom_range(0, 4);
         if (op < 2)       bus(1, 0, addr, wd, rd);
         else if (op < 4)  bus(0, 1, addr, wd, rd);
         else              bus(1, 1, addr, wd, rd);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mmio_responder.md
MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'hFFFF0000, byte base address of the register window SHALL be used for address decode.
REQ-002 Parameter PORT_W, default 8, width of the PortIn bus.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 MemRead  input  1  read request from the processor load/store stage.
REQ-006 MemWrite  input  1  write request from the processor load/store stage.
REQ-007 Address  input  32  byte address, held stable by the requester until Ready.
REQ-008 WriteData  input  32  store data, held stable until Ready.
REQ-009 ReadData  output  32  load data, valid only while Ready=1.
REQ-010 Ready  output  1  one-cycle completion pulse for the current request.
REQ-011 PortIn  input  PORT_W  asynchronous external inputs.
REQ-012 PortOut  output  32  registered output port.
REQ-013 IRQ  output  1  registered level interrupt to the processor.

Function
REQ-014 FSM SHALL have two states: IDLE and RESP; IDLE->RESP when MemRead|MemWrite=1; RESP->IDLE unconditionally.
REQ-015 Ready SHALL be 1 exactly in RESP; request latency SHALL be 1 cycle; maximum throughput one access per 2 cycles.
REQ-016 Requests present in RESP SHALL be ignored; the same held request SHALL NOT be executed twice.
REQ-017 MemRead=MemWrite=1 SHALL execute as a write; ReadData SHALL be 0 in that response.
REQ-018 Address decode on Address-BASE_ADDR; Address[1:0] ignored; offsets: 0x00 PORTOUT RW, 0x04 PORTIN RO, 0x08 EDGE W1C, 0x0C IRQEN RW [8:0], 0x10 TIMER RW, 0x14 TIMCMP RW, 0x18 STATUS W1C [0].
REQ-019 Unmapped offsets SHALL read 0, ignore writes, still complete with Ready.
REQ-020 Writes SHALL take effect on the IDLE->RESP edge; read data SHALL be captured on the same edge and held in RESP.
REQ-021 PortIn SHALL pass a 2-flop synchronizer; PORTIN read = zero-extended synchronized value.
REQ-022 EDGE[i] SHALL set on a 0->1 transition of synchronized PortIn[i]; set SHALL win over a same-cycle W1C.
REQ-023 TIMER SHALL increment by 1 each cycle, wrapping 0xFFFFFFFF->0; a TIMER write SHALL load WriteData and suppress that cycle's increment.
REQ-024 STATUS[0] SHALL set when TIMER==TIMCMP; set SHALL win over a same-cycle W1C.
REQ-025 IRQ SHALL be registered: |(EDGE & IRQEN[7:0]) | (STATUS[0] & IRQEN[8]), one cycle after the source changes.

Reset
REQ-026 reset=0 SHALL immediately force: state IDLE, Ready 0, ReadData 0, PortOut 0, IRQ 0, all registers and synchronizer flops 0.
REQ-027 Reset asserted in RESP SHALL abort the response; the requester SHALL reissue after release.
REQ-028 After reset release, the first edge detection SHALL require two cycles of synchronized input.

Structure
REQ-029 Shared package mmio_pkg SHALL hold register offsets, the IDLE/RESP state encoding and the default BASE_ADDR.
REQ-030 One sub-module sync_edge_detect (PORT_W-wide 2-flop synchronizer plus rising-edge pulse) SHALL be instantiated.
REQ-031 No combinational path SHALL exist from any input to ReadData, Ready or IRQ.

Verification
REQ-032 Write 0x000000A5 to 0xFFFF0000 -> Ready 1 cycle later, PortOut=0x000000A5, next read returns 0x000000A5.
REQ-033 PortIn 0x00->0x03, IRQEN=0x003 -> EDGE=0x03 and IRQ=1 within 4 cycles; write 0x01 to EDGE -> EDGE=0x02, IRQ stays 1.
REQ-034 Write TIMER=0xFFFFFFFE, TIMCMP=0x00000001, IRQEN=0x100 -> TIMER wraps to 0, STATUS[0]=1 three cycles after load, IRQ 1 cycle later.
REQ-035 MemRead+MemWrite both held on 0xFFFF0014 with WriteData 0x55 -> single Ready pulse, ReadData=0, TIMCMP=0x55, no second write.
REQ-036 Read 0xFFFF0040 -> ReadData=0, Ready=1; reset pulsed during RESP -> Ready and PortOut drop to 0 immediately.
